// File: rtl/med_display_driver.sv
// med_display_driver: renders a byte as two hex digits on a serial 7-segment
// chain (sclk/sdata/slatch) and drives a buzzer square wave while due is high.
module med_display_driver #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned BEEP_HALF = 1024
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ena,
  input  logic [7:0] i_disp_data,
  input  logic       i_disp_valid,
  input  logic       i_due,
  output logic       o_sclk,
  output logic       o_sdata,
  output logic       o_slatch,
  output logic       o_busy,
  output logic       o_buzzer
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BEEP_W = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_HALF - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_LATCH} state_t;

  // Hex digit to {dp,g,f,e,d,c,b,a}, active high
  function automatic logic [7:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 8'h3F;  4'h1: seg7 = 8'h06;  4'h2: seg7 = 8'h5B;  4'h3: seg7 = 8'h4F;
      4'h4: seg7 = 8'h66;  4'h5: seg7 = 8'h6D;  4'h6: seg7 = 8'h7D;  4'h7: seg7 = 8'h07;
      4'h8: seg7 = 8'h7F;  4'h9: seg7 = 8'h6F;  4'hA: seg7 = 8'h77;  4'hB: seg7 = 8'h7C;
      4'hC: seg7 = 8'h39;  4'hD: seg7 = 8'h5E;  4'hE: seg7 = 8'h79;  default: seg7 = 8'h71;
    endcase
  endfunction

  // Left digit carries the due flag on its decimal point
  function automatic logic [15:0] frame_word(input logic [7:0] d, input logic dp);
    frame_word = {seg7(d[7:4]) | {dp, 7'b0}, seg7(d[3:0])};
  endfunction

  state_t            r_state, w_state_nxt;
  logic [15:0]       r_word, w_word_nxt;
  logic [3:0]        r_bit_idx, w_bit_idx_nxt;
  logic [DIV_W-1:0]  r_div_cnt, w_div_cnt_nxt;
  logic              r_phase, w_phase_nxt;
  logic              r_pend, w_pend_nxt;
  logic [7:0]        r_pend_data, w_pend_data_nxt;
  logic              r_sclk, r_sdata, r_slatch, r_busy, r_buzzer;
  logic              w_sclk_nxt, w_sdata_nxt, w_slatch_nxt, w_busy_nxt;
  logic [BEEP_W-1:0] r_beep_cnt;

  logic       w_div_last, w_shift_done, w_reload;
  logic [7:0] w_load_data;

  assign w_div_last   = (r_div_cnt == DIV_LAST);
  assign w_shift_done = w_div_last && r_phase && (r_bit_idx == 4'd0);
  assign w_reload     = i_disp_valid || r_pend;
  // A strobe coinciding with the end of LATCH is newer than the pending byte
  assign w_load_data  = (r_state == S_LATCH && !i_disp_valid) ? r_pend_data : i_disp_data;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst)      r_state <= S_IDLE;
    else if (i_ena) r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_disp_valid) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_shift_done) w_state_nxt = S_LATCH;
      S_LATCH: if (w_div_last) w_state_nxt = w_reload ? S_LOAD : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and output next values, aligned with the next state
  always_comb begin
    w_word_nxt      = r_word;
    w_bit_idx_nxt   = r_bit_idx;
    w_div_cnt_nxt   = r_div_cnt;
    w_phase_nxt     = r_phase;
    w_pend_nxt      = r_pend;
    w_pend_data_nxt = r_pend_data;

    case (r_state)
      S_SHIFT: begin
        if (w_div_last) begin
          w_div_cnt_nxt = '0;
          w_phase_nxt   = ~r_phase;
          if (r_phase && r_bit_idx != 4'd0) w_bit_idx_nxt = r_bit_idx - 4'd1;
        end else begin
          w_div_cnt_nxt = r_div_cnt + DIV_W'(1);
        end
      end
      S_LATCH: w_div_cnt_nxt = w_div_last ? '0 : r_div_cnt + DIV_W'(1);
      default: w_div_cnt_nxt = '0;
    endcase

    if (r_state != S_IDLE && i_disp_valid) begin
      w_pend_nxt      = 1'b1;
      w_pend_data_nxt = i_disp_data;
    end

    if (w_state_nxt == S_LOAD) begin
      w_word_nxt    = frame_word(w_load_data, i_due);
      w_bit_idx_nxt = 4'd15;
      w_div_cnt_nxt = '0;
      w_phase_nxt   = 1'b0;
      if (r_state == S_LATCH) w_pend_nxt = 1'b0;
    end

    w_sclk_nxt   = (w_state_nxt == S_SHIFT) && w_phase_nxt;
    w_sdata_nxt  = (w_state_nxt == S_LOAD || w_state_nxt == S_SHIFT) ? w_word_nxt[w_bit_idx_nxt] : 1'b0;
    w_slatch_nxt = (w_state_nxt == S_LATCH);
    w_busy_nxt   = (w_state_nxt != S_IDLE);
  end

  // Datapath and registered display outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_word      <= '0;
      r_bit_idx   <= '0;
      r_div_cnt   <= '0;
      r_phase     <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_data <= '0;
      r_sclk      <= 1'b0;
      r_sdata     <= 1'b0;
      r_slatch    <= 1'b0;
      r_busy      <= 1'b0;
    end else if (i_ena) begin
      r_word      <= w_word_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_div_cnt   <= w_div_cnt_nxt;
      r_phase     <= w_phase_nxt;
      r_pend      <= w_pend_nxt;
      r_pend_data <= w_pend_data_nxt;
      r_sclk      <= w_sclk_nxt;
      r_sdata     <= w_sdata_nxt;
      r_slatch    <= w_slatch_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Buzzer square wave while due, independent of the display frame
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_beep_cnt <= '0;
      r_buzzer   <= 1'b0;
    end else if (i_ena) begin
      if (!i_due) begin
        r_beep_cnt <= '0;
        r_buzzer   <= 1'b0;
      end else if (r_beep_cnt == BEEP_LAST) begin
        r_beep_cnt <= '0;
        r_buzzer   <= ~r_buzzer;
      end else begin
        r_beep_cnt <= r_beep_cnt + BEEP_W'(1);
      end
    end
  end

  assign o_sclk   = r_sclk;
  assign o_sdata  = r_sdata;
  assign o_slatch = r_slatch;
  assign o_busy   = r_busy;
  assign o_buzzer = r_buzzer;

endmodule

// File: tb/tb_med_display_driver.sv
// Bench for med_display_driver: table-driven frames, multi-cycle corner
// sequences and a randomized run against a frame-position reference model.
module tb_med_display_driver;
  localparam int unsigned CLK_DIV   = 4;
  localparam int unsigned BEEP_HALF = 8;
  localparam int D  = int'(CLK_DIV);
  localparam int BH = int'(BEEP_HALF);
  localparam int FRAME_LAT = 2 + 33 * D;   // strobe cycle to busy low
  localparam int LAST_POS  = 33 * D;       // last LATCH cycle, LOAD is pos 0

  logic       clk;
  logic       rst, ena, disp_valid, due;
  logic [7:0] disp_data;
  logic       o_sclk, o_sdata, o_slatch, o_busy, o_buzzer;

  med_display_driver #(.CLK_DIV(CLK_DIV), .BEEP_HALF(BEEP_HALF)) dut (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_disp_data(disp_data),
    .i_disp_valid(disp_valid), .i_due(due), .o_sclk(o_sclk), .o_sdata(o_sdata),
    .o_slatch(o_slatch), .o_busy(o_busy), .o_buzzer(o_buzzer));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: frame position counter plus pending byte, due run length
  logic [7:0]  seg_tab [16];
  bit          m_active, m_pend;
  int          m_pos, m_run;
  logic [15:0] m_word;
  logic [7:0]  m_pend_data;

  // Capture of what a 74HC595 chain would see
  logic [15:0] cap;
  int          rises, lat_cycles;
  logic        prev_sclk, prev_slatch;
  logic [15:0] frame_q[$];
  int          rise_q[$];

  function automatic logic [15:0] mk_word(input logic [7:0] d, input logic dp);
    logic [7:0] hi, lo;
    hi = seg_tab[d[7:4]];
    lo = seg_tab[d[3:0]];
    hi[7] = dp;
    return {hi, lo};
  endfunction

  function automatic logic [4:0] model_outs();
    logic sc, sd, sl;
    int k;
    sc = 1'b0; sd = 1'b0; sl = 1'b0;
    if (m_active) begin
      if (m_pos == 0) sd = m_word[15];
      else if (m_pos <= 32 * D) begin
        k  = m_pos - 1;
        sc = ((k % (2 * D)) >= D);
        sd = m_word[15 - k / (2 * D)];
      end else sl = 1'b1;
    end
    return {sc, sd, sl, m_active, ((m_run / BH) % 2) == 1};
  endfunction

  task automatic model_step();
    if (rst) begin
      m_active = 0; m_pend = 0; m_pos = 0; m_run = 0; m_word = '0; m_pend_data = '0;
    end else if (ena) begin
      if (!m_active) begin
        if (disp_valid) begin m_active = 1; m_pos = 0; m_word = mk_word(disp_data, due); end
      end else if (m_pos == LAST_POS) begin
        if (disp_valid) begin m_word = mk_word(disp_data, due); m_pos = 0; m_pend = 0; end
        else if (m_pend) begin m_word = mk_word(m_pend_data, due); m_pos = 0; m_pend = 0; end
        else m_active = 0;
      end else begin
        m_pos++;
        if (disp_valid) begin m_pend = 1; m_pend_data = disp_data; end
      end
      m_run = due ? m_run + 1 : 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  // One clock: advance model with sampled inputs, compare, update capture
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    check("outs{sclk,sdata,slatch,busy,buz}", {27'd0, o_sclk, o_sdata, o_slatch, o_busy, o_buzzer},
          {27'd0, model_outs()});
    if (o_sclk && !prev_sclk) begin cap = {cap[14:0], o_sdata}; rises++; end
    if (o_slatch && !prev_slatch) begin
      frame_q.push_back(cap); rise_q.push_back(rises); cap = '0; rises = 0;
    end
    if (o_slatch) lat_cycles++;
    prev_sclk   = o_sclk;
    prev_slatch = o_slatch;
  endtask

  task automatic clear_cap();
    cap = '0; rises = 0; lat_cycles = 0;
    frame_q.delete(); rise_q.delete();
  endtask

  task automatic idle(input int n);
    disp_valid = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [15:0] q_word(input int i);
    if (frame_q.size() > i) return frame_q[i];
    return 16'hDEAD;
  endfunction

  typedef struct {
    logic [7:0]  data;
    logic        dp;
    logic [15:0] word;
  } vec_t;
  vec_t tbl[8];

  task automatic run_single(input vec_t v);
    int n;
    idle(3);
    clear_cap();
    due = v.dp; disp_data = v.data; disp_valid = 1;
    tick();
    disp_valid = 0;
    n = 1;
    while (o_busy && n < 400) begin tick(); n++; end
    check("frame_latency", 32'(n), 32'(FRAME_LAT));
    check("frame_count", 32'(frame_q.size()), 32'd1);
    check("frame_word", {16'd0, q_word(0)}, {16'd0, v.word});
    check("sclk_rises", 32'(rise_q.size() > 0 ? rise_q[0] : -1), 32'd16);
    check("slatch_len", 32'(lat_cycles), 32'(D));
    due = 0;
  endtask

  initial begin
    int n;
    int tog[$];
    logic pb;
    seg_tab = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    tbl[0] = '{8'h3A, 1'b0, 16'h4F77};
    tbl[1] = '{8'h3A, 1'b1, 16'hCF77};
    tbl[2] = '{8'hF0, 1'b0, 16'h713F};
    tbl[3] = '{8'h12, 1'b0, 16'h065B};
    tbl[4] = '{8'h56, 1'b0, 16'h6D7D};
    tbl[5] = '{8'hFF, 1'b1, 16'hF171};
    tbl[6] = '{8'h89, 1'b0, 16'h7F6F};
    tbl[7] = '{8'hBC, 1'b1, 16'hFC39};
    prev_sclk = 0; prev_slatch = 0;
    clear_cap();
    rst = 1; ena = 1; disp_valid = 0; due = 0; disp_data = '0;
    tick(); tick();
    rst = 0;

    // Idle after reset
    idle(50);
    check("idle_outs", {27'd0, o_sclk, o_sdata, o_slatch, o_busy, o_buzzer}, 32'd0);

    // Single frames from the vector table
    foreach (tbl[i]) run_single(tbl[i]);

    // Back-to-back: latest pending byte wins, busy stays high
    idle(3); clear_cap();
    disp_data = 8'h12; disp_valid = 1; tick(); n = 1;
    while (o_busy && n < 600) begin
      disp_valid = (n == 10 || n == 50);
      disp_data  = (n == 10) ? 8'h34 : 8'h56;
      tick(); n++;
    end
    check("b2b_latency", 32'(n), 32'(1 + 2 * (LAST_POS + 1)));
    check("b2b_count", 32'(frame_q.size()), 32'd2);
    check("b2b_word0", {16'd0, q_word(0)}, 32'h065B);
    check("b2b_word1", {16'd0, q_word(1)}, 32'h6D7D);

    // Strobe on the last LATCH cycle is carried into the next frame
    idle(3); clear_cap();
    disp_data = 8'h12; disp_valid = 1; tick(); n = 1;
    while (o_busy && n < 600) begin
      disp_valid = (n == LAST_POS + 1);
      disp_data  = 8'h9A;
      tick(); n++;
    end
    check("edge_latency", 32'(n), 32'(1 + 2 * (LAST_POS + 1)));
    check("edge_word1", {16'd0, q_word(1)}, 32'h6F77);

    // ena low for 20 cycles mid-SHIFT; strobe during freeze is ignored
    idle(3); clear_cap();
    disp_data = 8'h3A; disp_valid = 1; tick(); n = 1;
    while (o_busy && n < 600) begin
      ena = !(n >= 40 && n < 60);
      disp_valid = (n == 45);
      disp_data  = 8'h55;
      tick(); n++;
    end
    ena = 1;
    idle(150);
    check("freeze_latency", 32'(n), 32'(FRAME_LAT + 20));
    check("freeze_count", 32'(frame_q.size()), 32'd1);
    check("freeze_word", {16'd0, q_word(0)}, 32'h4F77);

    // Reset mid-SHIFT aborts the frame without a latch pulse
    idle(3); clear_cap();
    disp_data = 8'h3A; disp_valid = 1; tick(); disp_valid = 0;
    for (n = 1; n < 200; n++) begin
      rst = (n == 40);
      tick();
      if (n == 40) check("rst_outs", {27'd0, o_sclk, o_sdata, o_slatch, o_busy, o_buzzer}, 32'd0);
    end
    check("rst_no_latch", 32'(lat_cycles), 32'd0);
    check("rst_busy", {31'd0, o_busy}, 32'd0);

    // Buzzer: toggles every BEEP_HALF cycles while due, clears when due drops
    idle(3);
    due = 1; pb = o_buzzer;
    for (int c = 1; c <= 44; c++) begin
      tick();
      if (o_buzzer !== pb) tog.push_back(c);
      pb = o_buzzer;
    end
    check("buz_toggles", 32'(tog.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      check("buz_toggle_cycle", 32'(tog.size() > i ? tog[i] : -1), 32'(BH * (i + 1)));
    check("buz_high", {31'd0, o_buzzer}, 32'd1);
    due = 0; tick();
    check("buz_off", {31'd0, o_buzzer}, 32'd0);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 1999) == 0);
      ena        = ($urandom_range(0, 9) != 0);
      disp_valid = ($urandom_range(0, 39) == 0);
      disp_data  = 8'($urandom);
      if ($urandom_range(0, 149) == 0) due = ~due;
      tick();
    end
    rst = 0; ena = 1; due = 0;
    idle(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
